// File: rtl/ysyx_220066_alu_arbiter_if.sv
// Request/response/ALU bundle between two ALU requesters and the EX-stage ALU arbiter.
// Latency: none (signal bundle only).
// Backpressure: valid/ready per request and per response; ALU side is purely combinational.
interface ysyx_220066_alu_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [63:0]      req0_a;
    logic [63:0]      req0_b;
    logic [4:0]       req0_ctr;
    logic [TAG_W-1:0] req0_tag;
    logic             resp0_valid;
    logic             resp0_ready;
    logic [63:0]      resp0_result;
    logic             resp0_zero;
    logic [2:0]       resp0_lowbit;
    logic [TAG_W-1:0] resp0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [63:0]      req1_a;
    logic [63:0]      req1_b;
    logic [4:0]       req1_ctr;
    logic [TAG_W-1:0] req1_tag;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [63:0]      resp1_result;
    logic             resp1_zero;
    logic [2:0]       resp1_lowbit;
    logic [TAG_W-1:0] resp1_tag;

    logic [63:0]      alu_a;
    logic [63:0]      alu_b;
    logic [4:0]       alu_ctr;
    logic [63:0]      alu_result;
    logic             alu_zero;
    logic [2:0]       alu_lowbit;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctr, req0_tag, resp0_ready,
        output req0_ready, resp0_valid, resp0_result, resp0_zero, resp0_lowbit, resp0_tag,
        input  req1_valid, req1_a, req1_b, req1_ctr, req1_tag, resp1_ready,
        output req1_ready, resp1_valid, resp1_result, resp1_zero, resp1_lowbit, resp1_tag,
        output alu_a, alu_b, alu_ctr, busy,
        input  alu_result, alu_zero, alu_lowbit
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctr, req0_tag, resp0_ready,
        input  req0_ready, resp0_valid, resp0_result, resp0_zero, resp0_lowbit, resp0_tag,
        output req1_valid, req1_a, req1_b, req1_ctr, req1_tag, resp1_ready,
        input  req1_ready, resp1_valid, resp1_result, resp1_zero, resp1_lowbit, resp1_tag,
        input  alu_a, alu_b, alu_ctr, busy,
        output alu_result, alu_zero, alu_lowbit
    );
endinterface

// File: rtl/ysyx_220066_alu_arbiter.sv
// Two-port arbiter sharing one combinational ALU; round-robin, or port 0 fixed priority when YSYX_220066_ALU_ARB_FIXED_PRIO_EN is defined.
// Latency: 1 cycle from request accept to response valid.
// Backpressure: a port is granted only if its response slot is empty or draining this cycle.
module ysyx_220066_alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_220066_alu_arbiter_if.slave bus
);

    typedef struct packed {
        logic [63:0]      result;
        logic             zero;
        logic [2:0]       lowbit;
        logic [TAG_W-1:0] tag;
    } slot_t;

    slot_t slot0_q;
    slot_t slot1_q;
    logic  resp0_valid_q;
    logic  resp1_valid_q;
    logic  last_q;
    logic  elig0;
    logic  elig1;
    logic  gnt0;
    logic  gnt1;

    // A full slot that drains this cycle can take a new result on the same edge.
    assign elig0 = bus.req0_valid && (!resp0_valid_q || bus.resp0_ready);
    assign elig1 = bus.req1_valid && (!resp1_valid_q || bus.resp1_ready);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifdef YSYX_220066_ALU_ARB_FIXED_PRIO_EN
        gnt0 = elig0;
        gnt1 = elig1 && !elig0;
`else
        gnt0 = elig0 && (!elig1 || last_q);
        gnt1 = elig1 && (!elig0 || !last_q);
`endif
    end

    always_comb begin
        bus.alu_a   = 64'd0;
        bus.alu_b   = 64'd0;
        bus.alu_ctr = 5'd0;
        if (gnt0) begin
            bus.alu_a   = bus.req0_a;
            bus.alu_b   = bus.req0_b;
            bus.alu_ctr = bus.req0_ctr;
        end else if (gnt1) begin
            bus.alu_a   = bus.req1_a;
            bus.alu_b   = bus.req1_b;
            bus.alu_ctr = bus.req1_ctr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q       <= '0;
            resp0_valid_q <= 1'b0;
        end else if (gnt0) begin
            slot0_q       <= '{bus.alu_result, bus.alu_zero, bus.alu_lowbit, bus.req0_tag};
            resp0_valid_q <= 1'b1;
        end else if (resp0_valid_q && bus.resp0_ready) begin
            resp0_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot1_q       <= '0;
            resp1_valid_q <= 1'b0;
        end else if (gnt1) begin
            slot1_q       <= '{bus.alu_result, bus.alu_zero, bus.alu_lowbit, bus.req1_tag};
            resp1_valid_q <= 1'b1;
        end else if (resp1_valid_q && bus.resp1_ready) begin
            resp1_valid_q <= 1'b0;
        end
    end

    // Reset value 1 makes port 0 the winner of the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (gnt0) begin
            last_q <= 1'b0;
        end else if (gnt1) begin
            last_q <= 1'b1;
        end
    end

    assign bus.req0_ready   = gnt0;
    assign bus.req1_ready   = gnt1;
    assign bus.resp0_valid  = resp0_valid_q;
    assign bus.resp0_result = slot0_q.result;
    assign bus.resp0_zero   = slot0_q.zero;
    assign bus.resp0_lowbit = slot0_q.lowbit;
    assign bus.resp0_tag    = slot0_q.tag;
    assign bus.resp1_valid  = resp1_valid_q;
    assign bus.resp1_result = slot1_q.result;
    assign bus.resp1_zero   = slot1_q.zero;
    assign bus.resp1_lowbit = slot1_q.lowbit;
    assign bus.resp1_tag    = slot1_q.tag;
    assign bus.busy         = resp0_valid_q | resp1_valid_q;

endmodule

// File: tb/tb_ysyx_220066_alu_arbiter.sv
// Directed bench for ysyx_220066_alu_arbiter with a small add/sub/addw ALU stand-in.
module tb_ysyx_220066_alu_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ysyx_220066_alu_arbiter_if #(.TAG_W(4)) bus ();

    ysyx_220066_alu_arbiter #(.TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: ctr[3] selects subtract, ctr[4] selects 32-bit sign-extended result.
    logic [63:0] alu_bm;
    logic [63:0] alu_sum;
    always_comb begin
        alu_bm         = bus.alu_ctr[3] ? (~bus.alu_b + 64'd1) : bus.alu_b;
        alu_sum        = bus.alu_a + alu_bm;
        bus.alu_zero   = (alu_sum == 64'd0);
        bus.alu_lowbit = alu_sum[2:0];
        bus.alu_result = bus.alu_ctr[4] ? {{32{alu_sum[31]}}, alu_sum[31:0]} : alu_sum;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic g0;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctr = '0; bus.req0_tag = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctr = '0; bus.req1_tag = '0;
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_resp0_valid", 64'(bus.resp0_valid), 64'd0);
        chk("rst_resp1_valid", 64'(bus.resp1_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_resp0_result", bus.resp0_result, 64'd0);
        chk("rst_resp1_tag", 64'(bus.resp1_tag), 64'd0);
        rst_n = 1'b1;
        tick();

        // Port 0 alone: 3 + 4
        bus.req0_valid = 1'b1; bus.req0_a = 64'd3; bus.req0_b = 64'd4; bus.req0_ctr = 5'b00000; bus.req0_tag = 4'd5;
        #1;
        chk("p0_only_req0_ready", 64'(bus.req0_ready), 64'd1);
        chk("p0_only_req1_ready", 64'(bus.req1_ready), 64'd0);
        chk("p0_only_alu_a", bus.alu_a, 64'd3);
        chk("p0_only_alu_b", bus.alu_b, 64'd4);
        tick();
        bus.req0_valid = 1'b0;
        chk("p0_only_resp_valid", 64'(bus.resp0_valid), 64'd1);
        chk("p0_only_result", bus.resp0_result, 64'd7);
        chk("p0_only_zero", 64'(bus.resp0_zero), 64'd0);
        chk("p0_only_lowbit", 64'(bus.resp0_lowbit), 64'd7);
        chk("p0_only_tag", 64'(bus.resp0_tag), 64'd5);
        chk("p0_only_busy", 64'(bus.busy), 64'd1);
        bus.resp0_ready = 1'b1;
        tick();
        chk("p0_drain_valid", 64'(bus.resp0_valid), 64'd0);
        chk("p0_drain_busy", 64'(bus.busy), 64'd0);

        // Port 1 alone, zero flag: 5 - 5
        bus.req1_valid = 1'b1; bus.req1_a = 64'd5; bus.req1_b = 64'd5; bus.req1_ctr = 5'b01000; bus.req1_tag = 4'd3;
        bus.resp1_ready = 1'b1;
        #1;
        chk("zero_req1_ready", 64'(bus.req1_ready), 64'd1);
        tick();
        bus.req1_valid = 1'b0;
        chk("zero_resp1_valid", 64'(bus.resp1_valid), 64'd1);
        chk("zero_result", bus.resp1_result, 64'd0);
        chk("zero_flag", 64'(bus.resp1_zero), 64'd1);
        chk("zero_tag", 64'(bus.resp1_tag), 64'd3);
        #1;
        chk("idle_alu_a", bus.alu_a, 64'd0);
        chk("idle_alu_b", bus.alu_b, 64'd0);
        chk("idle_alu_ctr", 64'(bus.alu_ctr), 64'd0);
        tick();

        // Contention: sub on port 0, addw overflow on port 1
        bus.req0_valid = 1'b1; bus.req0_a = 64'd10; bus.req0_b = 64'd3; bus.req0_ctr = 5'b01000; bus.req0_tag = 4'd1;
        bus.req1_valid = 1'b1; bus.req1_a = 64'h7FFF_FFFF; bus.req1_b = 64'd1; bus.req1_ctr = 5'b10000; bus.req1_tag = 4'd2;
        for (int k = 0; k < 4; k++) begin
`ifdef YSYX_220066_ALU_ARB_FIXED_PRIO_EN
            g0 = 1'b1;
`else
            g0 = (k % 2 == 0);
`endif
            #1;
            chk("arb_req0_ready", 64'(bus.req0_ready), 64'(g0));
            chk("arb_req1_ready", 64'(bus.req1_ready), 64'(!g0));
            chk("arb_alu_a", bus.alu_a, g0 ? 64'd10 : 64'h7FFF_FFFF);
            tick();
            if (g0) begin
                chk("arb_resp0_valid", 64'(bus.resp0_valid), 64'd1);
                chk("arb_resp0_result", bus.resp0_result, 64'd7);
                chk("arb_resp0_tag", 64'(bus.resp0_tag), 64'd1);
                chk("arb_resp1_idle", 64'(bus.resp1_valid), 64'd0);
            end else begin
                chk("arb_resp1_valid", 64'(bus.resp1_valid), 64'd1);
                chk("arb_resp1_result", bus.resp1_result, 64'hFFFF_FFFF_8000_0000);
                chk("arb_resp1_lowbit", 64'(bus.resp1_lowbit), 64'd0);
                chk("arb_resp1_tag", 64'(bus.resp1_tag), 64'd2);
                chk("arb_resp0_idle", 64'(bus.resp0_valid), 64'd0);
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        chk("arb_drained_busy", 64'(bus.busy), 64'd0);

        // Backpressure on port 0
        bus.resp0_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 64'd1; bus.req0_b = 64'd2; bus.req0_ctr = 5'b00000; bus.req0_tag = 4'd1;
        #1;
        chk("bp_first_ready", 64'(bus.req0_ready), 64'd1);
        tick();
        chk("bp_first_result", bus.resp0_result, 64'd3);
        bus.req0_a = 64'd20; bus.req0_b = 64'd22; bus.req0_tag = 4'd2;
        #1;
        chk("bp_blocked_ready", 64'(bus.req0_ready), 64'd0);
        tick();
        chk("bp_hold_valid", 64'(bus.resp0_valid), 64'd1);
        chk("bp_hold_result", bus.resp0_result, 64'd3);
        chk("bp_hold_tag", 64'(bus.resp0_tag), 64'd1);
        chk("bp_still_blocked", 64'(bus.req0_ready), 64'd0);
        bus.resp0_ready = 1'b1;
        #1;
        chk("bp_drain_ready", 64'(bus.req0_ready), 64'd1);
        tick();
        bus.req0_valid = 1'b0;
        chk("bp_reload_valid", 64'(bus.resp0_valid), 64'd1);
        chk("bp_reload_result", bus.resp0_result, 64'd42);
        chk("bp_reload_tag", 64'(bus.resp0_tag), 64'd2);
        tick();
        chk("bp_final_valid", 64'(bus.resp0_valid), 64'd0);

        // Asynchronous reset while port 1 holds a response
        bus.resp1_ready = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 64'd7; bus.req1_b = 64'd1; bus.req1_ctr = 5'b00000; bus.req1_tag = 4'd9;
        tick();
        chk("mid_resp1_valid", 64'(bus.resp1_valid), 64'd1);
        chk("mid_resp1_result", bus.resp1_result, 64'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp1_valid", 64'(bus.resp1_valid), 64'd0);
        chk("mid_rst_resp1_result", bus.resp1_result, 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        tick();
        #2;
        rst_n = 1'b1;
        bus.resp1_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 64'd1; bus.req0_b = 64'd1; bus.req0_ctr = 5'b00000; bus.req0_tag = 4'd4;
        #1;
        chk("post_rst_req0_ready", 64'(bus.req0_ready), 64'd1);
        chk("post_rst_req1_ready", 64'(bus.req1_ready), 64'd0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("post_rst_resp0_valid", 64'(bus.resp0_valid), 64'd1);
        chk("post_rst_resp0_result", bus.resp0_result, 64'd2);
        chk("post_rst_resp1_valid", 64'(bus.resp1_valid), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
